// File: rtl/sensor_frame_scheduler.sv
// Pairs quaternion/gyro strobes into sequenced frames and double-buffers them for the MCU.
// Optional per-frame checksum is built only when FRAME_CHK_EN is defined.
module sensor_frame_scheduler #(
    parameter int PAIR_TIMEOUT  = 3000,
    parameter int STALE_TIMEOUT = 300000,
    parameter int SEQ_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             quat_valid,
    input  logic [15:0]      quat_w,
    input  logic [15:0]      quat_x,
    input  logic [15:0]      quat_y,
    input  logic [15:0]      quat_z,
    input  logic             gyro_valid,
    input  logic [15:0]      gyro_x,
    input  logic [15:0]      gyro_y,
    input  logic [15:0]      gyro_z,
    input  logic             rd_cs_n,
    output logic [15:0]      frm_w,
    output logic [15:0]      frm_x,
    output logic [15:0]      frm_y,
    output logic [15:0]      frm_z,
    output logic [15:0]      frm_gx,
    output logic [15:0]      frm_gy,
    output logic [15:0]      frm_gz,
    output logic [SEQ_W-1:0] frm_seq,
    output logic [3:0]       frm_flags,
    output logic [7:0]       frm_chk,
    output logic [7:0]       drop_cnt
);

    localparam logic [15:0] PAIR_LIM  = 16'(PAIR_TIMEOUT - 1);
    localparam logic [23:0] STALE_MAX = 24'(STALE_TIMEOUT);

    typedef enum logic [1:0] {IDLE, HAVE_Q, HAVE_G, COMMIT} state_t;

    typedef struct packed {
        logic [15:0]      w;
        logic [15:0]      x;
        logic [15:0]      y;
        logic [15:0]      z;
        logic [15:0]      gx;
        logic [15:0]      gy;
        logic [15:0]      gz;
        logic [SEQ_W-1:0] seq;
        logic [3:0]       flags;
    } frame_t;

    state_t state, state_nxt, entry_nxt;

    logic        cs_meta, cs_sync, lock, lock_q, lock_fall;
    logic [15:0] stg_w, stg_x, stg_y, stg_z, stg_gx, stg_gy, stg_gz;
    logic        q_fresh, g_fresh;
    logic [15:0] pair_cnt;
    logic [23:0] stale_cnt;
    logic        pair_to, stale_hit, commit;
    logic        rd_sel, swap_pend;
    logic [SEQ_W-1:0] seq, seq_nxt;
    frame_t      bank [2];
    frame_t      cfrm;

    assign lock      = ~cs_sync;
    assign lock_fall = lock_q & ~lock;
    assign commit    = (state == COMMIT);
    assign pair_to   = (pair_cnt >= PAIR_LIM);
    assign stale_hit = (stale_cnt == STALE_MAX);
    assign seq_nxt   = seq + {{(SEQ_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_meta <= 1'b1;
            cs_sync <= 1'b1;
            lock_q  <= 1'b0;
        end else begin
            cs_meta <= rd_cs_n;
            cs_sync <= cs_meta;
            lock_q  <= lock;
        end
    end

    // Strobes always land in staging, even during the commit cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_w   <= '0;
            stg_x   <= '0;
            stg_y   <= '0;
            stg_z   <= '0;
            stg_gx  <= '0;
            stg_gy  <= '0;
            stg_gz  <= '0;
            q_fresh <= 1'b0;
            g_fresh <= 1'b0;
        end else begin
            if (quat_valid) begin
                stg_w   <= quat_w;
                stg_x   <= quat_x;
                stg_y   <= quat_y;
                stg_z   <= quat_z;
                q_fresh <= 1'b1;
            end else if (commit) begin
                q_fresh <= 1'b0;
            end
            if (gyro_valid) begin
                stg_gx  <= gyro_x;
                stg_gy  <= gyro_y;
                stg_gz  <= gyro_z;
                g_fresh <= 1'b1;
            end else if (commit) begin
                g_fresh <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pair_cnt  <= '0;
            stale_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (quat_valid || gyro_valid)
                pair_cnt <= 16'd1;
            else if ((state == HAVE_Q || state == HAVE_G) && pair_cnt != 16'hFFFF)
                pair_cnt <= pair_cnt + 16'd1;
            if (commit)
                stale_cnt <= '0;
            else if (!stale_hit)
                stale_cnt <= stale_cnt + 24'd1;
        end
    end

    always_comb begin
        entry_nxt = IDLE;
        if (quat_valid && gyro_valid)
            entry_nxt = COMMIT;
        else if (quat_valid)
            entry_nxt = HAVE_Q;
        else if (gyro_valid)
            entry_nxt = HAVE_G;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, COMMIT: state_nxt = entry_nxt;
            HAVE_Q: begin
                if (gyro_valid)
                    state_nxt = COMMIT;
                else if (quat_valid)
                    state_nxt = HAVE_Q;
                else if (pair_to)
                    state_nxt = COMMIT;
            end
            HAVE_G: begin
                if (quat_valid)
                    state_nxt = COMMIT;
                else if (gyro_valid)
                    state_nxt = HAVE_G;
                else if (pair_to)
                    state_nxt = COMMIT;
            end
        endcase
    end

    always_comb begin
        cfrm.w     = stg_w;
        cfrm.x     = stg_x;
        cfrm.y     = stg_y;
        cfrm.z     = stg_z;
        cfrm.gx    = stg_gx;
        cfrm.gy    = stg_gy;
        cfrm.gz    = stg_gz;
        cfrm.seq   = seq_nxt;
        cfrm.flags = {1'b0, swap_pend, g_fresh, q_fresh};
    end

    // Only the back bank is ever written by a commit; the reader's bank moves via rd_sel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank[0]   <= '0;
            bank[1]   <= '0;
            seq       <= '0;
            rd_sel    <= 1'b0;
            swap_pend <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (commit) begin
                bank[~rd_sel] <= cfrm;
                seq           <= seq_nxt;
                if (swap_pend && drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end else if (stale_hit) begin
                bank[rd_sel].flags[3] <= 1'b1;
            end
            if (commit && !lock) begin
                rd_sel    <= ~rd_sel;
                swap_pend <= 1'b0;
            end else if (commit) begin
                swap_pend <= 1'b1;
            end else if (lock_fall && swap_pend) begin
                rd_sel    <= ~rd_sel;
                swap_pend <= 1'b0;
            end
        end
    end

    assign frm_w     = bank[rd_sel].w;
    assign frm_x     = bank[rd_sel].x;
    assign frm_y     = bank[rd_sel].y;
    assign frm_z     = bank[rd_sel].z;
    assign frm_gx    = bank[rd_sel].gx;
    assign frm_gy    = bank[rd_sel].gy;
    assign frm_gz    = bank[rd_sel].gz;
    assign frm_seq   = bank[rd_sel].seq;
    assign frm_flags = bank[rd_sel].flags;

`ifdef FRAME_CHK_EN
    logic [SEQ_W+7:0] seq_ext;
    logic [7:0]       chk_nxt;
    logic [7:0]       chk_bank [2];

    assign seq_ext = {8'h00, seq_nxt};
    assign chk_nxt = stg_w[15:8]  ^ stg_w[7:0]  ^ stg_x[15:8]  ^ stg_x[7:0]
                   ^ stg_y[15:8]  ^ stg_y[7:0]  ^ stg_z[15:8]  ^ stg_z[7:0]
                   ^ stg_gx[15:8] ^ stg_gx[7:0] ^ stg_gy[15:8] ^ stg_gy[7:0]
                   ^ stg_gz[15:8] ^ stg_gz[7:0] ^ seq_ext[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_bank[0] <= '0;
            chk_bank[1] <= '0;
        end else if (commit) begin
            chk_bank[~rd_sel] <= chk_nxt;
        end
    end

    assign frm_chk = chk_bank[rd_sel];
`else
    assign frm_chk = 8'h00;
`endif

endmodule
